mm2s_cmd_gen: RTL and testbench

MM2S_CMD_GEN -- requirements
Module: mm2s_cmd_gen

---
 rtl/mm2s_cmd_gen_if.sv | 28 ++
 rtl/mm2s_cmd_gen.sv | 155 +++++++++++++++
 tb/tb_mm2s_cmd_gen.sv | 309 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mm2s_cmd_gen_if.sv
// DataMover MM2S command stream plus its status return, seen from the command generator (master)
// and from the DataMover side (slave).
interface mm2s_cmd_gen_if;
  logic [71:0] m_axis_tdata;
  logic        m_axis_tvalid;
  logic        m_axis_tready;
  logic        sts_valid;
  logic        sts_ok;
  logic [3:0]  sts_tag;

  modport master (
    output m_axis_tdata,
    output m_axis_tvalid,
    input  m_axis_tready,
    input  sts_valid,
    input  sts_ok,
    input  sts_tag
  );

  modport slave (
    input  m_axis_tdata,
    input  m_axis_tvalid,
    output m_axis_tready,
    output sts_valid,
    output sts_ok,
    output sts_tag
  );
endinterface

// File: rtl/mm2s_cmd_gen.sv
// Splits one memory-to-stream job into DataMover MM2S commands of at most CHUNK_BYTES each,
// limits commands in flight to MAX_OUTSTANDING and checks returned statuses in tag order.
module mm2s_cmd_gen #(
  parameter int unsigned CHUNK_BYTES     = 4096,
  parameter int unsigned MAX_OUTSTANDING = 4
) (
  input  logic           s_axi_clk,
  input  logic           s_axi_resetn,
  input  logic           start,
  input  logic [31:0]    start_addr,
  input  logic [31:0]    total_bytes,
  mm2s_cmd_gen_if.master dm,
  output logic           busy,
  output logic           done,
  output logic           error
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;
  localparam logic [1:0] S_FIN   = 2'd3;

  localparam logic [31:0] CHUNK     = 32'(CHUNK_BYTES);
  localparam logic [22:0] CHUNK_BTT = 23'(CHUNK_BYTES);
  localparam logic [3:0]  MAX_OUT   = 4'(MAX_OUTSTANDING);

  logic [1:0]  state_q, state_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] remaining_q, remaining_d;
  logic [3:0]  tag_q, tag_d;
  logic [3:0]  exp_tag_q, exp_tag_d;
  logic [3:0]  outstanding_q, outstanding_d;
  logic        tvalid_q, tvalid_d;
  logic [71:0] tdata_q, tdata_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        error_q, error_d;

  logic        hs;
  logic        sts_hit;
  logic        sts_spur;
  logic        sts_bad;
  logic        last_chunk;
  logic [22:0] chunk_len;
  logic [31:0] btt;
  logic [71:0] cmd_word;

  assign hs         = tvalid_q & dm.m_axis_tready;
  assign sts_hit    = dm.sts_valid & (outstanding_q != 4'd0);
  assign sts_spur   = dm.sts_valid & (outstanding_q == 4'd0) & busy_q;
  assign sts_bad    = sts_hit & (~dm.sts_ok | (dm.sts_tag != exp_tag_q));
  assign last_chunk = (remaining_q <= CHUNK);
  assign chunk_len  = last_chunk ? remaining_q[22:0] : CHUNK_BTT;
  // The accepted command's own BTT field is what gets retired from the job.
  assign btt        = {9'd0, tdata_q[22:0]};
  assign cmd_word   = {4'd0, tag_q, addr_q, 1'b0, last_chunk, 6'd0, 1'b1, chunk_len};

  always_comb begin
    state_d       = state_q;
    addr_d        = addr_q;
    remaining_d   = remaining_q;
    tag_d         = tag_q;
    exp_tag_d     = exp_tag_q;
    outstanding_d = outstanding_q;
    tvalid_d      = tvalid_q;
    tdata_d       = tdata_q;
    busy_d        = busy_q;
    done_d        = 1'b0;
    error_d       = error_q | sts_bad | sts_spur;

    case ({hs, sts_hit})
      2'b10:   outstanding_d = outstanding_q + 4'd1;
      2'b01:   outstanding_d = outstanding_q - 4'd1;
      default: outstanding_d = outstanding_q;
    endcase

    if (sts_hit) begin
      exp_tag_d = exp_tag_q + 4'd1;
    end

    case (state_q)
      S_IDLE: begin
        busy_d = 1'b0;
        if (start && !busy_q) begin
          addr_d      = start_addr;
          remaining_d = total_bytes;
          tag_d       = 4'd0;
          exp_tag_d   = 4'd0;
          error_d     = 1'b0;
          busy_d      = 1'b1;
          state_d     = (total_bytes == 32'd0) ? S_FIN : S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (hs) begin
          tvalid_d    = 1'b0;
          remaining_d = remaining_q - btt;
          addr_d      = addr_q + btt;
          tag_d       = tag_q + 4'd1;
          if (remaining_q == btt) begin
            state_d = S_DRAIN;
          end
        end else if (!tvalid_q && (outstanding_q < MAX_OUT)) begin
          tvalid_d = 1'b1;
          tdata_d  = cmd_word;
        end
      end
      S_DRAIN: begin
        if (outstanding_q == 4'd0) begin
          state_d = S_FIN;
        end
      end
      default: begin
        // busy stays high through the done cycle and drops in IDLE.
        done_d  = 1'b1;
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge s_axi_clk or negedge s_axi_resetn) begin
    if (!s_axi_resetn) begin
      state_q       <= S_IDLE;
      addr_q        <= 32'd0;
      remaining_q   <= 32'd0;
      tag_q         <= 4'd0;
      exp_tag_q     <= 4'd0;
      outstanding_q <= 4'd0;
      tvalid_q      <= 1'b0;
      tdata_q       <= 72'd0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      error_q       <= 1'b0;
    end else begin
      state_q       <= state_d;
      addr_q        <= addr_d;
      remaining_q   <= remaining_d;
      tag_q         <= tag_d;
      exp_tag_q     <= exp_tag_d;
      outstanding_q <= outstanding_d;
      tvalid_q      <= tvalid_d;
      tdata_q       <= tdata_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
      error_q       <= error_d;
    end
  end

  assign dm.m_axis_tvalid = tvalid_q;
  assign dm.m_axis_tdata  = tdata_q;
  assign busy             = busy_q;
  assign done             = done_q;
  assign error            = error_q;

endmodule

// File: tb/tb_mm2s_cmd_gen.sv
// Directed bench for mm2s_cmd_gen: expected commands are queued per job and checked by a
// monitor at each handshake; a status model answers accepted commands.
module tb_mm2s_cmd_gen;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [31:0] start_addr;
  logic [31:0] total_bytes;
  logic        busy;
  logic        done;
  logic        error;

  mm2s_cmd_gen_if dm ();

  mm2s_cmd_gen #(.CHUNK_BYTES(4096), .MAX_OUTSTANDING(4)) dut (
    .s_axi_clk    (clk),
    .s_axi_resetn (rst_n),
    .start        (start),
    .start_addr   (start_addr),
    .total_bytes  (total_bytes),
    .dm           (dm),
    .busy         (busy),
    .done         (done),
    .error        (error)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         due;
    logic [3:0] tag;
  } pend_t;

  logic [71:0] exp_q[$];
  pend_t       pend_q[$];
  int          n_cmp = 0;
  int          n_bad = 0;
  int          hs_cnt = 0;
  int          cyc = 0;
  int          sts_lag = 5;
  bit          sts_en = 0;
  int          rel_req = 0;
  int          rel_done = 0;
  int          bad_mode = 0;
  logic [3:0]  bad_tag = 4'd0;
  int          h0;
  int          k;
  bit          e;
  logic [71:0] mon_prev_data;
  bit          mon_prev_wait = 0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [71:0] cmd(input logic [22:0] b, input logic [31:0] a,
                                      input logic [3:0] t, input bit eof);
    cmd = {4'd0, t, a, 1'b0, eof, 6'd0, 1'b1, b};
  endfunction

  task automatic chk(input string name, input logic [71:0] act, input logic [71:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic pulse_start(input logic [31:0] a, input logic [31:0] n);
    start_addr  = a;
    total_bytes = n;
    start       = 1'b1;
    step();
    start       = 1'b0;
  endtask

  task automatic wait_done(input string name, input int limit, output bit err_at_done);
    int c = 0;
    while (done !== 1'b1 && c < limit) begin
      step();
      c++;
    end
    if (done !== 1'b1) begin
      n_cmp++;
      n_bad++;
      err_at_done = 1'b0;
      $display("FAIL %s_timeout: done not seen within %0d cycles", name, limit);
    end else begin
      err_at_done = error;
      $display("job %s: done after %0d cycles, error=%0b", name, c, error);
      chk({name, "_busy_at_done"}, busy, 1);
      step();
      chk({name, "_done_one_cycle"}, done, 0);
      chk({name, "_busy_after"}, busy, 0);
    end
  endtask

  // Command monitor: handshakes pop the expected queue; a waiting command must hold steady.
  initial begin
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        mon_prev_wait = 0;
      end else begin
        if (mon_prev_wait) begin
          chk("hold_tvalid", dm.m_axis_tvalid, 1);
          chk("hold_tdata", dm.m_axis_tdata, mon_prev_data);
        end
        if (dm.m_axis_tvalid && dm.m_axis_tready) begin
          hs_cnt++;
          $display("cmd %0d: tdata=%018h", hs_cnt, dm.m_axis_tdata);
          if (exp_q.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL unexpected_cmd: got %018h expected none", dm.m_axis_tdata);
          end else begin
            chk("cmd_word", dm.m_axis_tdata, exp_q.pop_front());
          end
          pend_q.push_back('{cyc + sts_lag, dm.m_axis_tdata[67:64]});
          mon_prev_wait = 0;
        end else begin
          mon_prev_wait = dm.m_axis_tvalid;
          mon_prev_data = dm.m_axis_tdata;
        end
      end
    end
  end

  // Status model: answers accepted commands after sts_lag, or one at a time on release.
  initial begin
    pend_t p;
    dm.sts_valid = 1'b0;
    dm.sts_ok    = 1'b0;
    dm.sts_tag   = 4'd0;
    forever begin
      @(posedge clk);
      #1;
      dm.sts_valid = 1'b0;
      if (pend_q.size() != 0 && (rel_req > rel_done || (sts_en && pend_q[0].due <= cyc))) begin
        if (rel_req > rel_done) rel_done++;
        p = pend_q.pop_front();
        dm.sts_valid = 1'b1;
        dm.sts_ok    = !(bad_mode == 1 && p.tag == bad_tag);
        dm.sts_tag   = (bad_mode == 2 && p.tag == bad_tag) ? 4'd5 : p.tag;
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n            = 1'b0;
    start            = 1'b0;
    start_addr       = 32'd0;
    total_bytes      = 32'd0;
    dm.m_axis_tready = 1'b0;
    step(2);
    chk("rst_tvalid", dm.m_axis_tvalid, 0);
    chk("rst_tdata", dm.m_axis_tdata, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_error", error, 0);
    rst_n = 1'b1;
    step(2);

    // Basic 10000-byte job, 3 chunks
    h0 = hs_cnt;
    exp_q.push_back(72'h00_10000000_00801000);
    exp_q.push_back(72'h01_10001000_00801000);
    exp_q.push_back(72'h02_10002000_40800710);
    dm.m_axis_tready = 1'b1;
    sts_en = 1;
    pulse_start(32'h1000_0000, 32'd10000);
    wait_done("basic", 200, e);
    chk("basic_error", e, 0);
    chk("basic_ncmd", hs_cnt - h0, 3);
    chk("basic_all_issued", exp_q.size(), 0);

    // Zero-length job
    h0 = hs_cnt;
    start_addr = 32'h5000_0000;
    total_bytes = 32'd0;
    start = 1'b1;
    step();
    start = 1'b0;
    chk("zero_busy_c1", busy, 1);
    chk("zero_done_c1", done, 0);
    step();
    chk("zero_busy_c2", busy, 1);
    chk("zero_done_c2", done, 1);
    step();
    chk("zero_busy_c3", busy, 0);
    chk("zero_done_c3", done, 0);
    chk("zero_ncmd", hs_cnt - h0, 0);
    chk("zero_error", error, 0);

    // Outstanding limit: 8 chunks, statuses withheld
    h0 = hs_cnt;
    sts_en = 0;
    for (int i = 0; i < 8; i++)
      exp_q.push_back(cmd(23'd4096, 32'h2000_0000 + 32'(i) * 32'd4096, 4'(i), i == 7));
    pulse_start(32'h2000_0000, 32'd32768);
    step(30);
    chk("limit_ncmd4", hs_cnt - h0, 4);
    chk("limit_tvalid_low", dm.m_axis_tvalid, 0);
    rel_req++;
    step(15);
    chk("limit_ncmd5", hs_cnt - h0, 5);
    chk("limit_tvalid_low2", dm.m_axis_tvalid, 0);
    sts_en = 1;
    wait_done("limit", 300, e);
    chk("limit_error", e, 0);
    chk("limit_ncmd", hs_cnt - h0, 8);

    // Back-pressure: tready low for 10 cycles
    h0 = hs_cnt;
    dm.m_axis_tready = 1'b0;
    exp_q.push_back(cmd(23'd4096, 32'h3000_0000, 4'd0, 0));
    exp_q.push_back(cmd(23'd4096, 32'h3000_1000, 4'd1, 1));
    pulse_start(32'h3000_0000, 32'd8192);
    k = 0;
    while (dm.m_axis_tvalid !== 1'b1 && k < 20) begin
      step();
      k++;
    end
    chk("bp_tvalid_up", dm.m_axis_tvalid, 1);
    step(10);
    chk("bp_tvalid_held", dm.m_axis_tvalid, 1);
    chk("bp_no_accept", hs_cnt - h0, 0);
    dm.m_axis_tready = 1'b1;
    step();
    chk("bp_accept_once", hs_cnt - h0, 1);
    wait_done("bp", 200, e);
    chk("bp_error", e, 0);

    // Bad status: second status not OKAY
    h0 = hs_cnt;
    bad_mode = 1;
    bad_tag = 4'd1;
    for (int i = 0; i < 4; i++)
      exp_q.push_back(cmd(23'd4096, 32'h4000_0000 + 32'(i) * 32'd4096, 4'(i), i == 3));
    pulse_start(32'h4000_0000, 32'd16384);
    wait_done("bad_ok", 300, e);
    chk("bad_ok_error", e, 1);
    chk("bad_ok_ncmd", hs_cnt - h0, 4);
    chk("bad_ok_sticky", error, 1);

    // Bad status: second status carries tag 5; start clears the old error
    h0 = hs_cnt;
    bad_mode = 2;
    for (int i = 0; i < 4; i++)
      exp_q.push_back(cmd(23'd4096, 32'h4800_0000 + 32'(i) * 32'd4096, 4'(i), i == 3));
    pulse_start(32'h4800_0000, 32'd16384);
    chk("bad_tag_cleared", error, 0);
    wait_done("bad_tag", 300, e);
    chk("bad_tag_error", e, 1);
    chk("bad_tag_ncmd", hs_cnt - h0, 4);
    bad_mode = 0;

    // Address wrap across 2^32
    h0 = hs_cnt;
    exp_q.push_back(cmd(23'd4096, 32'hFFFF_F000, 4'd0, 0));
    exp_q.push_back(cmd(23'd4096, 32'h0000_0000, 4'd1, 1));
    pulse_start(32'hFFFF_F000, 32'd8192);
    wait_done("wrap", 200, e);
    chk("wrap_error", e, 0);
    chk("wrap_all_issued", exp_q.size(), 0);

    // Same job, reset asserted after the first handshake
    h0 = hs_cnt;
    exp_q.push_back(cmd(23'd4096, 32'hFFFF_F000, 4'd0, 0));
    exp_q.push_back(cmd(23'd4096, 32'h0000_0000, 4'd1, 1));
    pulse_start(32'hFFFF_F000, 32'd8192);
    k = 0;
    while (hs_cnt == h0 && k < 20) begin
      step();
      k++;
    end
    chk("rstjob_first_cmd", hs_cnt - h0, 1);
    dm.m_axis_tready = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    chk("rstjob_tvalid", dm.m_axis_tvalid, 0);
    chk("rstjob_tdata", dm.m_axis_tdata, 0);
    chk("rstjob_busy", busy, 0);
    chk("rstjob_done", done, 0);
    chk("rstjob_error", error, 0);
    step(2);
    rst_n = 1'b1;
    exp_q.delete();
    step(15);
    chk("rstjob_spurious_error", error, 0);
    chk("rstjob_idle_busy", busy, 0);
    chk("rstjob_idle_tvalid", dm.m_axis_tvalid, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
